// File: rtl/vga_sprite_pkg.sv
// vga_sprite_pkg: shared types and constants for the card sprite pixel source
package vga_sprite_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  localparam int CARD_W = 32;
  localparam int CARD_H = 64;
  localparam logic [11:0] DEF_KEY_COLOR = 12'h000;
endpackage

// File: rtl/sprite_dp_ram.sv
// sprite_dp_ram: simple dual-port RAM, synchronous write port and read-first synchronous read port
module sprite_dp_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/vga_card_sprite_src.sv
// vga_card_sprite_src: card bitmap pixel source with region compare, 2-cycle read pipeline and clear engine
module vga_card_sprite_src
  import vga_sprite_pkg::*;
#(
  parameter int             CD         = 12,
  parameter logic [CD-1:0]  KEY_COLOR  = CD'(DEF_KEY_COLOR),
  parameter int             H_BITS     = 5,
  parameter int             V_BITS     = 6,
  parameter int             ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [10:0]           x0,
  input  logic [10:0]           y0,
  input  logic                  hflip,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [CD-1:0]         pixel_in,
  input  logic                  clr_start,
  output logic                  busy,
  output logic [CD-1:0]         card_rgb
);
  clr_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_hit1;
  logic [H_BITS-1:0]     w_xr, w_col;
  logic [V_BITS-1:0]     w_yr;
  logic [11:0]           w_xe, w_ye;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_rd_addr, w_wa;
  logic                  w_we;
  logic [CD-1:0]         w_wd, w_q;
  // Bounds are widened to 12 bits so an origin near 2047 cannot wrap back onto column 0.
  assign w_xe      = {1'b0, x0} + 12'(2**H_BITS);
  assign w_ye      = {1'b0, y0} + 12'(2**V_BITS);
  assign w_hit     = (x >= x0) && ({1'b0, x} < w_xe) && (y >= y0) && ({1'b0, y} < w_ye);
  assign w_xr      = H_BITS'(x - x0);
  assign w_yr      = V_BITS'(y - y0);
  assign w_col     = hflip ? ~w_xr : w_xr;
  assign w_rd_addr = {w_yr, w_col};
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_state_nxt;
  always_comb w_state_nxt = (r_state == IDLE) ? (clr_start ? CLEAR : IDLE) : (&r_cnt ? IDLE : CLEAR);
  // A reset edge also suppresses the in-flight clear write, leaving the RAM partially cleared.
  always_comb begin
    busy = (r_state == CLEAR);
    w_we = busy ? !reset : we;
    w_wa = busy ? r_cnt : addr_w;
    w_wd = busy ? KEY_COLOR : pixel_in;
  end
  always_ff @(posedge clk) r_cnt <= (reset || r_state == IDLE) ? '0 : r_cnt + 1'b1;
  always_ff @(posedge clk) begin
    r_hit1   <= reset ? 1'b0 : w_hit;
    card_rgb <= (reset || !r_hit1) ? KEY_COLOR : w_q;
  end
  sprite_dp_ram #(.DATA_WIDTH(CD), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wa),
    .i_wdata (w_wd),
    .i_raddr (w_rd_addr),
    .o_rdata (w_q)
  );
endmodule

// File: tb/tb_vga_card_sprite_src.sv
// tb_vga_card_sprite_src: table-driven scoreboard bench for the card sprite pixel source
module tb_vga_card_sprite_src;
  localparam logic [11:0] KEY = 12'h000;
  logic        clk = 0, reset = 1, hflip = 0, we = 0, clr_start = 0, busy;
  logic [10:0] x = 0, y = 0, x0 = 0, y0 = 0, addr_w = 0;
  logic [11:0] pixel_in = 0, card_rgb;
  int n_chk = 0, n_err = 0, cyc = 0;
  typedef struct {logic chk; logic [11:0] exp; string nm; int cyc;} sb_t;
  typedef struct {logic [10:0] x, y, x0, y0; logic hf; logic [11:0] exp; string nm;} vec_t;
  sb_t  q[$];
  vec_t tv[14];
  vga_card_sprite_src dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .x0(x0), .y0(y0), .hflip(hflip),
    .we(we), .addr_w(addr_w), .pixel_in(pixel_in), .clr_start(clr_start),
    .busy(busy), .card_rgb(card_rgb)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // One pixel per negedge; the entry driven two steps earlier is due on card_rgb now.
  task automatic step(input logic [10:0] ix, iy, ix0, iy0, input logic ih, input logic c,
                      input logic [11:0] e, input string nm);
    sb_t s;
    if (q.size() > 0 && q[0].cyc == cyc - 2) begin
      s = q.pop_front();
      if (s.chk) check(s.nm, card_rgb, s.exp);
    end
    x = ix; y = iy; x0 = ix0; y0 = iy0; hflip = ih;
    q.push_back('{c, e, nm, cyc});
    cyc++;
    @(negedge clk);
  endtask
  task automatic flush();
    repeat (2) step(0, 0, 0, 0, 0, 0, KEY, "idle");
    q.delete();
  endtask
  task automatic wr(input int a, input logic [11:0] d);
    we = 1; addr_w = 11'(a); pixel_in = d;
    @(negedge clk);
    we = 0;
  endtask
  task automatic read_addr(input int a, input logic [11:0] e, input string nm);
    step(11'(a % 32), 11'(a / 32), 0, 0, 0, 1, e, nm);
  endtask
  initial begin
    int n;
    tv[0]  = '{0,    0,   100,  200, 0, KEY,    "outside"};
    tv[1]  = '{107,  203, 100,  200, 0, 12'hF00, "hit_3_7"};
    tv[2]  = '{117,  203, 100,  200, 1, 12'h0A0, "hflip_col14"};
    tv[3]  = '{124,  203, 100,  200, 1, 12'hF00, "hflip_col7"};
    tv[4]  = '{99,   203, 100,  200, 0, KEY,    "left_edge"};
    tv[5]  = '{131,  203, 100,  200, 0, 12'h123, "col31"};
    tv[6]  = '{132,  203, 100,  200, 0, KEY,    "right_edge"};
    tv[7]  = '{100,  203, 100,  200, 1, 12'h123, "hflip_x0"};
    tv[8]  = '{107,  199, 100,  200, 0, KEY,    "above"};
    tv[9]  = '{107,  263, 100,  200, 0, 12'h777, "row63"};
    tv[10] = '{107,  264, 100,  200, 0, KEY,    "below"};
    tv[11] = '{2047, 203, 2040, 200, 0, 12'hF00, "x0_2040_in"};
    tv[12] = '{5,    203, 2040, 200, 0, KEY,    "x0_2040_nowrap"};
    tv[13] = '{107,  203, 100,  200, 0, 12'hF00, "hit_again"};
    repeat (3) @(negedge clk);
    check("reset_rgb", card_rgb, KEY);
    check("reset_busy", 12'(busy), 0);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 100, 100, 0, 1, KEY, "idle_key");
      check("idle_busy", 12'(busy), 0);
    end
    flush();
    wr(3 * 32 + 7, 12'hF00);
    wr(3 * 32 + 14, 12'h0A0);
    wr(3 * 32 + 31, 12'h123);
    wr(63 * 32 + 7, 12'h777);
    for (int i = 0; i < 14; i++) step(tv[i].x, tv[i].y, tv[i].x0, tv[i].y0, tv[i].hf, 1, tv[i].exp, tv[i].nm);
    flush();
    // Full clear: a bus write at cycle 10 must be dropped, a second start at 20 ignored.
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    n = 0;
    while (busy && n < 3000) begin
      n++;
      we = (n == 10); addr_w = 11'd2; pixel_in = 12'hABC;
      clr_start = (n == 20);
      @(negedge clk);
    end
    we = 0; clr_start = 0;
    check("busy_cycles", 12'(n), 12'd2048);
    for (int a = 0; a < 2048; a++) read_addr(a, KEY, "cleared");
    flush();
    for (int a = 490; a <= 520; a++) wr(a, 12'(a) ^ 12'h5A5);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    check("busy_start", 12'(busy), 1);
    repeat (499) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("busy_after_reset", 12'(busy), 0);
    reset = 0;
    @(negedge clk);
    check("busy_stays_idle", 12'(busy), 0);
    for (int a = 490; a <= 520; a++) read_addr(a, (a < 499) ? KEY : (12'(a) ^ 12'h5A5), "partial_clear");
    flush();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
